// File: rtl/approx_softmax_pkg.sv
// Shared constants, FSM state encoding and a small saturation helper for
// the approximate softmax unit.
package approx_softmax_pkg;

   localparam int LANES    = 16;     // vector lanes
   localparam int DW       = 8;      // lane data width (int8 in, Q0.8 out)
   localparam int EW       = 16;     // width of one exp approximation
   localparam int SW       = 20;     // width of the exp sum
   localparam int RW       = 25;     // width of the reciprocal 2^24/S
   localparam int LOG2E_Q4 = 23;     // log2(e) ~ 1.4375 in Q4
   localparam int ONE_Q15  = 32768;  // 1.0 in Q15

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EXP  = 3'd1,
      ST_SUM  = 3'd2,
      ST_DIV  = 3'd3,
      ST_NORM = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   // Clamp a non-negative scaled probability to the 8-bit output range.
   function automatic logic [DW-1:0] sat_u8(input logic [RW-1:0] v);
      return (|v[RW-1:DW]) ? {DW{1'b1}} : v[DW-1:0];
   endfunction

endpackage

// File: rtl/softmax_recip_div.sv
// Sequential restoring divider computing R = floor(2^24 / S), one quotient
// bit per clock, MSB first, 25 bits in total.
//
// Handshake: i_start is a single-cycle pulse sampled together with i_s; the
// edge that samples it already produces quotient bit 24. o_busy is high
// while later bits are still being produced. o_done is high during the cycle
// whose closing edge writes quotient bit 0, so o_r is final from the next
// cycle on and holds until the following i_start.
// With S = 0 every trial subtraction succeeds, so R saturates to all ones.
module softmax_recip_div
   import approx_softmax_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [SW-1:0] i_s,
   output logic [RW-1:0] o_r,
   output logic          o_busy,
   output logic          o_done
);

   logic          r_busy;
   logic [4:0]    r_idx;
   logic [SW-1:0] r_rem;
   logic [SW-1:0] r_s;
   logic [RW-1:0] r_q;

   logic          w_step;
   logic [4:0]    w_idx;
   logic [SW-1:0] w_s;
   logic [SW-1:0] w_rem_in;
   logic [SW:0]   w_shift;
   logic          w_ge;
   logic [SW-1:0] w_rem_nx;

   // Operands of the current step: a start pulse restarts from a zero remainder.
   always_comb begin
      w_step   = i_start | r_busy;
      w_idx    = i_start ? 5'(RW - 1) : r_idx;
      w_s      = i_start ? i_s : r_s;
      w_rem_in = i_start ? '0 : r_rem;
      // The dividend 2^24 has a single one, at the first bit brought down.
      w_shift  = {w_rem_in, (w_idx == 5'(RW - 1))};
      w_ge     = (w_shift >= {1'b0, w_s});
      w_rem_nx = w_ge ? SW'(w_shift - {1'b0, w_s}) : SW'(w_shift);
   end

   // One restoring step per active cycle; quotient bits shift in from the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_idx  <= '0;
         r_rem  <= '0;
         r_s    <= '0;
         r_q    <= '0;
      end else if (w_step) begin
         r_s    <= w_s;
         r_rem  <= w_rem_nx;
         r_q    <= {r_q[RW-2:0], w_ge};
         r_idx  <= w_idx - 5'd1;
         r_busy <= (w_idx != 5'd0);
      end
   end

   assign o_r    = r_q;
   assign o_busy = r_busy;
   assign o_done = r_busy && (r_idx == 5'd0);

endmodule

// File: rtl/approx_softmax.sv
// Approximate 16-lane softmax: base-2 exp of (max - x) per lane, sum,
// sequential reciprocal, then per-lane scaling to Q0.8 probabilities.
// Build option: define APPROX_SOFTMAX_FRAC_EN to include the linear
// fractional interpolation term in the exp; otherwise the exp is a pure
// power of two.
//
// Handshake: softmax_en is a level request sampled only in IDLE; the edge
// that sees it high captures the vector and vec_max. Exactly one run per
// capture; approx_softmax_done_wire pulses for one cycle when the registered
// approx_softmax_wire carries the new result, which then holds until the next
// run finishes or reset.
module approx_softmax
   import approx_softmax_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LANES*DW-1:0] quantized_data_wire,
   input  logic [15:0]         vec_max_wire,
   input  logic                softmax_en,
   output logic [LANES*DW-1:0] approx_softmax_wire,
   output logic                approx_softmax_done_wire,
   output logic [2:0]          o_dbg_state
);

   state_t              r_state;
   logic [LANES*DW-1:0] r_x;
   logic [15:0]         r_max;
   logic [LANES*EW-1:0] r_e;
   logic [SW-1:0]       r_s;
   logic                r_div_start;
   logic [LANES*DW-1:0] r_y;
   logic                r_done;

   logic [LANES*EW-1:0] w_e;
   logic [LANES*DW-1:0] w_y;
   logic [SW-1:0]       w_sum;
   logic [RW-1:0]       w_r;
   logic                w_div_busy;
   logic                w_div_done;

   // Per-lane exp approximation (from captured inputs) and normalisation.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [16:0]   w_d;
      logic [7:0]    w_dc;
      logic [8:0]    w_n;
      logic [EW-1:0] w_base;
      logic [EW-1:0] w_ev;
      logic [RW-1:0] w_scaled;

      // d = max - x in 17-bit two's complement, then clamped to [0,255].
      assign w_d  = {r_max[15], r_max}
                  - {{9{r_x[g*DW+DW-1]}}, r_x[g*DW +: DW]};
      assign w_dc = w_d[16]        ? 8'd0   :
                    (|w_d[15:8])   ? 8'd255 : w_d[7:0];

`ifdef APPROX_SOFTMAX_FRAC_EN
      logic [12:0] w_t;
      // t = d*log2(e) in Q4: integer part shifts, fraction interpolates.
      assign w_t    = 13'(w_dc) * 13'(LOG2E_Q4);
      assign w_n    = w_t[12:4];
      assign w_base = EW'(ONE_Q15) - {2'b00, w_t[3:0], 10'd0};
`else
      // Only the integer part of d*log2(e) is used.
      assign w_n    = 9'((13'(w_dc) * 13'(LOG2E_Q4)) >> 4);
      assign w_base = EW'(ONE_Q15);
`endif

      assign w_ev = (w_n > 9'd15) ? '0 : (w_base >> w_n[3:0]);
      assign w_e[g*EW +: EW] = w_ev;

      // y = min(255, (e * R) >> 16); the full product is 41 bits.
      assign w_scaled = RW'((41'(r_e[g*EW +: EW]) * 41'(w_r)) >> 16);
      assign w_y[g*DW +: DW] = sat_u8(w_scaled);
   end

   // Adder tree over the registered exp values.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         w_sum = w_sum + SW'(r_e[i*EW +: EW]);
      end
   end

   softmax_recip_div u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (r_div_start),
      .i_s     (r_s),
      .o_r     (w_r),
      .o_busy  (w_div_busy),
      .o_done  (w_div_done)
   );

   // Control FSM with registered datapath stages and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_max       <= '0;
         r_e         <= '0;
         r_s         <= '0;
         r_div_start <= 1'b0;
         r_y         <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_div_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (softmax_en) begin
                  r_x     <= quantized_data_wire;
                  r_max   <= vec_max_wire;
                  r_state <= ST_EXP;
               end
            end
            ST_EXP: begin
               r_e     <= w_e;
               r_state <= ST_SUM;
            end
            ST_SUM: begin
               r_s         <= w_sum;
               r_div_start <= 1'b1;
               r_state     <= ST_DIV;
            end
            ST_DIV: begin
               // Leave as the final quotient bit is written this edge.
               if (w_div_busy && w_div_done) begin
                  r_state <= ST_NORM;
               end
            end
            ST_NORM: begin
               r_y     <= w_y;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign approx_softmax_wire      = r_y;
   assign approx_softmax_done_wire = r_done;
   assign o_dbg_state              = r_state;

endmodule

// File: tb/tb_approx_softmax.sv
// Testbench for approx_softmax: directed scenarios plus randomized vectors,
// all checked against a plain-arithmetic reference model of the softmax rules.
module tb_approx_softmax;

   logic         clk;
   logic         rst_n;
   logic [127:0] data;
   logic [15:0]  vmax;
   logic         en;
   logic [127:0] y_out;
   logic         done;
   logic [2:0]   dbg;

   int checks;
   int failures;

   approx_softmax dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .quantized_data_wire      (data),
      .vec_max_wire             (vmax),
      .softmax_en               (en),
      .approx_softmax_wire      (y_out),
      .approx_softmax_done_wire (done),
      .o_dbg_state              (dbg)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: exp, sum, reciprocal and normalisation in integer arithmetic.
   function automatic void ref_model(input logic [127:0] x, input logic [15:0] mx,
                                     output logic [127:0] y, output int s, output int r);
      int e [16];
      int d;
      int t;
      int n;
      int base;
      longint p;
      logic signed [7:0] xb;
      s = 0;
      for (int i = 0; i < 16; i++) begin
         xb = x[i*8 +: 8];
         d = int'($signed(mx)) - int'(xb);
         if (d < 0) d = 0;
         if (d > 255) d = 255;
         t = d * 23;
         n = t / 16;
`ifdef APPROX_SOFTMAX_FRAC_EN
         base = 32768 - (t % 16) * 1024;
`else
         base = 32768;
`endif
         e[i] = (n >= 16) ? 0 : base / (1 << n);
         s += e[i];
      end
      r = (s == 0) ? ((1 << 25) - 1) : ((1 << 24) / s);
      y = '0;
      for (int i = 0; i < 16; i++) begin
         p = (longint'(e[i]) * longint'(r)) / 65536;
         if (p > 255) p = 255;
         y[i*8 +: 8] = p[7:0];
      end
   endfunction

   // Drive one vector, watch the done pulse and compare against the model.
   // With scramble set, inputs and softmax_en are randomized after capture.
   task automatic run_vec(input string name, input logic [127:0] x,
                          input logic [15:0] mx, input bit scramble);
      logic [127:0] exp_y;
      int es;
      int er;
      int lat;
      int nd;
      ref_model(x, mx, exp_y, es, er);
      @(negedge clk);
      data = x;
      vmax = mx;
      en   = 1'b1;
      @(posedge clk);
      #1;
      lat = -1;
      nd  = 0;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         if (scramble && cyc < 28) begin
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            vmax = 16'($urandom());
            en   = 1'($urandom_range(0, 1));
         end else begin
            en = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) lat = cyc;
         end
      end
      en = 1'b0;
      checks++;
      if (lat !== 28) begin
         failures++;
         $display("FAIL %s done_latency got=%0d expected=28", name, lat);
      end
      checks++;
      if (nd !== 1) begin
         failures++;
         $display("FAIL %s done_pulses got=%0d expected=1", name, nd);
      end
      checks++;
      if (y_out !== exp_y) begin
         failures++;
         $display("FAIL %s probs got=%h expected=%h", name, y_out, exp_y);
      end
      checks++;
      if (dut.r_s !== 20'(es)) begin
         failures++;
         $display("FAIL %s sum got=%0d expected=%0d", name, dut.r_s, es);
      end
      checks++;
      if (dut.w_r !== 25'(er)) begin
         failures++;
         $display("FAIL %s recip got=%0d expected=%0d", name, dut.w_r, er);
      end
      checks++;
      if (dbg !== 3'd0) begin
         failures++;
         $display("FAIL %s end_state got=%0d expected=0", name, dbg);
      end
   endtask

   function automatic logic [127:0] scen1_vec();
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(127 - i / 2);
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      data  = '0;
      vmax  = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (y_out !== '0 || done !== 1'b0 || dbg !== 3'd0) begin
         failures++;
         $display("FAIL reset_values got y=%h done=%b state=%0d expected y=0 done=0 state=0",
                  y_out, done, dbg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (y_out !== '0 || done !== 1'b0 || dbg !== 3'd0) begin
         failures++;
         $display("FAIL after_reset got y=%h done=%b state=%0d expected y=0 done=0 state=0",
                  y_out, done, dbg);
      end
   endtask

   task automatic test_graded();
      logic [127:0] k;
      logic [7:0] kb [16];
      kb = '{8'd79, 8'd79, 8'd30, 8'd30, 8'd11, 8'd11, 8'd4, 8'd4,
             8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      for (int i = 0; i < 16; i++) k[i*8 +: 8] = kb[i];
      run_vec("graded", scen1_vec(), 16'sd127, 1'b0);
`ifdef APPROX_SOFTMAX_FRAC_EN
      checks++;
      if (y_out !== k || dut.r_s !== 20'd105790 || dut.w_r !== 25'd158) begin
         failures++;
         $display("FAIL graded_const got y=%h S=%0d R=%0d expected y=%h S=105790 R=158",
                  y_out, dut.r_s, dut.w_r, k);
      end
`else
      checks++;
      if (dut.r_s !== 20'd121664 || dut.w_r !== 25'd137) begin
         failures++;
         $display("FAIL graded_const got S=%0d R=%0d expected S=121664 R=137",
                  dut.r_s, dut.w_r);
      end
`endif
   endtask

   task automatic test_uniform();
      run_vec("uniform", {16{8'd5}}, 16'sd5, 1'b0);
      checks++;
      if (y_out !== {16{8'd16}} || dut.r_s !== 20'd524288 || dut.w_r !== 25'd32) begin
         failures++;
         $display("FAIL uniform_const got y=%h S=%0d R=%0d expected all 16 S=524288 R=32",
                  y_out, dut.r_s, dut.w_r);
      end
   endtask

   task automatic test_saturate();
      logic [127:0] x;
      logic [127:0] k;
      x = {16{8'h9C}};
      x[3*8 +: 8] = 8'd100;
      k = '0;
      k[3*8 +: 8] = 8'd255;
      run_vec("saturate", x, 16'sd100, 1'b0);
      checks++;
      if (y_out !== k) begin
         failures++;
         $display("FAIL saturate_const got=%h expected=%h", y_out, k);
      end
   endtask

   task automatic test_two_hot();
      logic [127:0] x;
      x = {16{8'h80}};
      x[7:0]  = 8'd10;
      x[15:8] = 8'd9;
      run_vec("two_hot", x, 16'sd10, 1'b0);
`ifndef APPROX_SOFTMAX_FRAC_EN
      checks++;
      if (y_out[7:0] !== 8'd170 || y_out[15:8] !== 8'd85 ||
          dut.r_s !== 20'd49152 || dut.w_r !== 25'd341) begin
         failures++;
         $display("FAIL two_hot_const got y0=%0d y1=%0d S=%0d R=%0d expected 170 85 49152 341",
                  y_out[7:0], y_out[15:8], dut.r_s, dut.w_r);
      end
`endif
   endtask

   task automatic test_reset_mid_run();
      int nd;
      @(negedge clk);
      data = scen1_vec();
      vmax = 16'sd127;
      en   = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y_out !== '0 || done !== 1'b0 || dbg !== 3'd0 || dut.r_s !== '0 || dut.w_r !== '0) begin
         failures++;
         $display("FAIL mid_reset got y=%h done=%b state=%0d S=%0d R=%0d expected all zero",
                  y_out, done, dbg, dut.r_s, dut.w_r);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int cyc = 0; cyc < 35; cyc++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) nd++;
      end
      checks++;
      if (nd !== 0 || y_out !== '0) begin
         failures++;
         $display("FAIL mid_reset_quiet got pulses=%0d y=%h expected pulses=0 y=0", nd, y_out);
      end
      run_vec("after_reset_rerun", scen1_vec(), 16'sd127, 1'b0);
   endtask

   task automatic test_scramble();
      logic [127:0] x;
      for (int i = 0; i < 16; i++) x[i*8 +: 8] = 8'($urandom_range(60, 127));
      run_vec("scramble_a", x, 16'sd127, 1'b1);
      run_vec("scramble_b", {16{8'd5}}, 16'sd5, 1'b1);
   endtask

   task automatic test_random();
      logic [127:0] x;
      logic [15:0] mx;
      int tmax;
      int mode;
      logic signed [7:0] xb;
      for (int it = 0; it < 10; it++) begin
         tmax = -128;
         for (int i = 0; i < 16; i++) begin
            x[i*8 +: 8] = 8'($urandom());
            xb = x[i*8 +: 8];
            if (int'(xb) > tmax) tmax = int'(xb);
         end
         mode = $urandom_range(0, 2);
         if (mode == 0)      mx = 16'(tmax);
         else if (mode == 1) mx = 16'(tmax + $urandom_range(0, 20));
         else                mx = 16'($urandom_range(0, 500) - 200);
         run_vec($sformatf("random_%0d", it), x, mx, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] xa;
      logic [127:0] xb;
      logic [127:0] ya;
      logic [127:0] yb;
      logic [127:0] ea;
      logic [127:0] eb;
      int s;
      int r;
      int nd;
      xa = scen1_vec();
      xb = {16{8'd5}};
      ref_model(xa, 16'sd127, ea, s, r);
      ref_model(xb, 16'sd5, eb, s, r);
      ya = '0;
      yb = '0;
      @(negedge clk);
      data = xa;
      vmax = 16'sd127;
      en   = 1'b1;
      @(posedge clk);
      #1;
      data = xb;
      vmax = 16'sd5;
      nd = 0;
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            nd++;
            if (nd == 1) ya = y_out;
            if (nd == 2) begin
               yb = y_out;
               en = 1'b0;
            end
         end
      end
      en = 1'b0;
      checks++;
      if (nd !== 2) begin
         failures++;
         $display("FAIL b2b_pulses got=%0d expected=2", nd);
      end
      checks++;
      if (ya !== ea) begin
         failures++;
         $display("FAIL b2b_first got=%h expected=%h", ya, ea);
      end
      checks++;
      if (yb !== eb) begin
         failures++;
         $display("FAIL b2b_second got=%h expected=%h", yb, eb);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_graded();
      test_uniform();
      test_saturate();
      test_two_hot();
      test_reset_mid_run();
      test_scramble();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
